// File: rtl/csa_mp_seq.sv
// Multi-precision adder that time-shares one 16-bit conditional-sum adder across NWORDS slices.
// Optional macro CSA_MP_SUB_EN adds a 'sub' port for A-B (registers ~b and forces carry-in to 1).

module csa16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  // Each level holds sums/carries for both carry-in hypotheses; blocks double in width per level.
  for (genvar l = 0; l < 5; l++) begin : lvl
    localparam int NB = 16 >> l;
    logic [15:0]   s0, s1;
    logic [NB-1:0] c0, c1;
    if (l == 0) begin : g_leaf
      assign s0 = a ^ b;
      assign s1 = ~(a ^ b);
      assign c0 = a & b;
      assign c1 = a | b;
    end else begin : g_merge
      localparam int N = 1 << l;
      localparam int H = N / 2;
      for (genvar j = 0; j < NB; j++) begin : g_blk
        assign s0[j*N +: H]   = lvl[l-1].s0[j*N +: H];
        assign s1[j*N +: H]   = lvl[l-1].s1[j*N +: H];
        assign s0[j*N+H +: H] = lvl[l-1].c0[2*j] ? lvl[l-1].s1[j*N+H +: H] : lvl[l-1].s0[j*N+H +: H];
        assign s1[j*N+H +: H] = lvl[l-1].c1[2*j] ? lvl[l-1].s1[j*N+H +: H] : lvl[l-1].s0[j*N+H +: H];
        assign c0[j] = lvl[l-1].c0[2*j] ? lvl[l-1].c1[2*j+1] : lvl[l-1].c0[2*j+1];
        assign c1[j] = lvl[l-1].c1[2*j] ? lvl[l-1].c1[2*j+1] : lvl[l-1].c0[2*j+1];
      end
    end
  end

  assign s    = cin ? lvl[4].s1    : lvl[4].s0;
  assign cout = cin ? lvl[4].c1[0] : lvl[4].c0[0];
endmodule

module csa_mp_seq #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*NWORDS-1:0] a,
  input  logic [16*NWORDS-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*NWORDS-1:0] s,
  output logic                 cout,
  output logic                 ovf
`ifdef CSA_MP_SUB_EN
  ,
  input  logic                 sub
`endif
);
  localparam int W  = 16 * NWORDS;
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  a_r, b_r;
  logic          carry;
  logic [IW-1:0] idx;
  logic [15:0]   add_s;
  logic          add_c;
  logic [W-1:0]  b_eff;
  logic          cin_eff;

`ifdef CSA_MP_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  csa16 u_add (
    .a    (a_r[16*idx +: 16]),
    .b    (b_r[16*idx +: 16]),
    .cin  (carry),
    .s    (add_s),
    .cout (add_c)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = RUN;
      RUN:     if (idx == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b_eff;
          carry <= cin_eff;
          idx   <= '0;
        end
        RUN: begin
          s[16*idx +: 16] <= add_s;
          carry           <= add_c;
          idx             <= idx + ONE;
          // Top slice: the fresh sum msb is what decides signed overflow.
          if (idx == LAST) begin
            cout <= add_c;
            ovf  <= (a_r[W-1] == b_r[W-1]) && (add_s[15] != a_r[W-1]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_mp_seq.sv
// Directed-vector bench for csa_mp_seq (NWORDS=4): sums, carry ripple, overflow, backpressure, reset.
`timescale 1ns/1ps
module tb_csa_mp_seq;
  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         cout, ovf;
`ifdef CSA_MP_SUB_EN
  logic         sub = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  csa_mp_seq #(.NWORDS(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
`ifdef CSA_MP_SUB_EN
    , .sub(sub)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer one operand set, then scramble the inputs while the block is busy.
  task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check("ready_before_accept", W'(in_ready), W'(1));
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~av; b = {bv[W/2-1:0], bv[W-1:W/2]}; cin = ~cv;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    check({tag, "_latency"}, W'(n), W'(NW));
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    check({tag, "_s"},    s,        es);
    check({tag, "_cout"}, W'(cout), W'(ec));
    check({tag, "_ovf"},  W'(ovf),  W'(eo));
  endtask

  task automatic release_res(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_vld_clr"}, W'(out_valid), W'(0));
    check({tag, "_idle"},    W'(in_ready),  W'(1));
  endtask

  task automatic run(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input logic cv, input logic [W-1:0] es, input logic ec, input logic eo);
    start(av, bv, cv);
    wait_done(tag);
    check_res(tag, es, ec, eo);
    release_res(tag);
  endtask

  initial begin
    #1;
    check("rst_s", s, '0);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_cout_ovf", W'({cout, ovf}), W'(0));
    #12 rst = 1'b0;
    step();
    check("post_rst_ready", W'(in_ready), W'(1));

    run("basic",  64'h0000_0000_0000_99CD, 64'h0000_0000_0000_36D6, 1'b0, 64'h0000_0000_0000_D0A3, 1'b0, 1'b0);
    run("basic_c", 64'h0000_0000_0000_99CD, 64'h0000_0000_0000_36D6, 1'b1, 64'h0000_0000_0000_D0A4, 1'b0, 1'b0);
    run("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
    run("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
    run("mixed",  64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles while new offers are ignored.
    start(64'h0000_0000_0000_99CD, 64'h0000_0000_0000_36D6, 1'b0);
    wait_done("bp");
    for (int i = 0; i < 5; i++) begin
      a = 64'hDEAD_BEEF_0000_1111; b = 64'h1; in_valid = i[0];
      step();
      check("bp_hold_s", s, 64'h0000_0000_0000_D0A3);
      check("bp_hold_flags", W'({out_valid, in_ready, cout, ovf}), W'(4'b1000));
    end
    in_valid = 1'b0;
    release_res("bp");

    // Reset mid-RUN at idx==2.
    start(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0);
    step(); step();
    rst = 1'b1;
    #1;
    check("mid_rst_s", s, '0);
    check("mid_rst_flags", W'({out_valid, in_ready, cout, ovf}), W'(4'b0100));
    #10 rst = 1'b0;
    step();
    check("mid_rst_ready", W'(in_ready), W'(1));
    run("after_rst", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0);

`ifdef CSA_MP_SUB_EN
    sub = 1'b1;
    run("sub", 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
